// File: rtl/key_event_reader.sv
// -----------------------------------------------------------------------------
// key_event_reader
//
// Consumer side of the keypad register interface. Watches the keypad's sticky
// 16-bit key register, snapshots it whenever it is non-zero while idle, pulses
// key_clear once per snapshot, and serialises every set bit of the snapshot
// (lowest index first) into 4-bit key codes through a small circular FIFO.
// Game control logic drains the codes with a valid/ready handshake.
//
// Parameters:
//   FIFO_DEPTH    event FIFO entries (power of two, >= 2)
//   GUARD_CYCLES  idle cycles after a drain before key_data is sampled again,
//                 giving the keypad time to apply key_clear (1..7)
//
// Ports:
//   clk            system clock
//   rstn           asynchronous active-low reset
//   key_interrupt  OR of the keypad's per-key pulses (wake hint only)
//   key_data       sticky key register; bit i = key i pressed since last clear
//   key_clear      one-cycle pulse clearing the keypad's key register
//   evt_valid      FIFO non-empty; evt_code holds the head entry
//   evt_ready      consumer accepts the head entry when evt_valid is high
//   evt_code       key index at the FIFO head (0 when empty)
//   evt_level      current FIFO occupancy
//   busy           high while draining a snapshot or waiting out the guard
// -----------------------------------------------------------------------------
module key_event_reader #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned GUARD_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          key_interrupt,
    input  logic [15:0]                   key_data,
    output logic                          key_clear,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [3:0]                    evt_code,
    output logic [$clog2(FIFO_DEPTH):0]   evt_level,
    output logic                          busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [2:0]    GUARD_L = 3'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [15:0]    snap_q, snap_d;
    logic [2:0]     guard_q, guard_d;
    logic           clear_q, clear_d;
    logic           busy_q, busy_d;

    logic [3:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [LW-1:0]  count_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic           fifo_nonempty;
    logic           pop;
    logic           push;
    logic           push_ok;
    logic [3:0]     low_idx;
    logic           low_found;

    // Capture is decided by key_data alone; key_interrupt carries no extra
    // information for this reader and is deliberately left unused.
    logic           unused_key_interrupt;
    assign unused_key_interrupt = key_interrupt;

    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty && evt_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok       = (count_q < DEPTH_L) || pop;

    // Index of the lowest set bit of the snapshot.
    always_comb begin
        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_q[i] && !low_found) begin
                low_idx   = 4'(i);
                low_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State machine: next state, snapshot, guard counter, registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        guard_d = guard_q;
        clear_d = 1'b0;
        push    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (key_data != '0) begin
                    snap_d  = key_data;
                    clear_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if ((snap_q != '0) && push_ok) begin
                    push   = 1'b1;
                    // x & (x-1) drops the lowest set bit, the one being pushed.
                    snap_d = snap_q & (snap_q - 16'd1);
                end
                // Leaving as soon as the last bit is pushed keeps a k-bit
                // snapshot at exactly k DRAIN cycles.
                if (snap_d == '0) begin
                    state_d = ST_GUARD;
                    guard_d = GUARD_L;
                end
            end

            ST_GUARD: begin
                if (guard_q <= 3'd1) begin
                    guard_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                snap_d  = '0;
                guard_d = '0;
            end
        endcase

        // busy is registered, so it is computed from the state being entered.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            guard_q <= '0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            guard_q <= guard_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (circular buffer, pointers wrap naturally at FIFO_DEPTH)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= low_idx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign key_clear = clear_q;
    assign busy      = busy_q;
    assign evt_level = count_q;
    assign evt_valid = fifo_nonempty;
    assign evt_code  = fifo_nonempty ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_key_event_reader.sv
// -----------------------------------------------------------------------------
// tb_key_event_reader
//
// Self-checking bench for key_event_reader. A sticky keypad register is
// emulated in the bench (cleared by key_clear, set by injected presses). A
// behavioural model keeps the pending key indices and the FIFO contents as
// queues and predicts every output each cycle; directed scenarios add
// explicit checks, followed by randomized presses and backpressure.
// -----------------------------------------------------------------------------
module tb_key_event_reader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned GUARD = 1;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_GUARD = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          key_interrupt;
    logic [15:0]   key_data;
    logic          key_clear;
    logic          evt_valid;
    logic          evt_ready;
    logic [3:0]    evt_code;
    logic [LW-1:0] evt_level;
    logic          busy;

    key_event_reader #(
        .FIFO_DEPTH   (DEPTH),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .key_interrupt (key_interrupt),
        .key_data      (key_data),
        .key_clear     (key_clear),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_level     (evt_level),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    int          m_state;
    int          m_pending[$];
    int          m_q[$];
    int          m_guard_left;
    bit          m_clear;

    // Keypad emulation and observation
    logic [15:0] kd_cur;
    int          clear_pulses;
    int          popped[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("key_clear", 32'(key_clear), 32'(m_clear));
        check_val("evt_valid", 32'(evt_valid), (m_q.size() != 0) ? 32'd1 : 32'd0);
        check_val("evt_code",  32'(evt_code),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check_val("evt_level", 32'(evt_level), 32'(m_q.size()));
        check_val("busy",      32'(busy),      (m_state != M_IDLE) ? 32'd1 : 32'd0);
    endtask

    task automatic check_pops(input string tag, input int exp[$]);
        check_val({tag, "_count"}, 32'(popped.size()), 32'(exp.size()));
        foreach (exp[i])
            check_val(tag, 32'((i < popped.size()) ? popped[i] : -1), 32'(exp[i]));
    endtask

    task automatic model_reset();
        m_state      = M_IDLE;
        m_pending.delete();
        m_q.delete();
        m_guard_left = 0;
        m_clear      = 1'b0;
    endtask

    // One clock edge of the reader as described by its rules.
    task automatic model_step(input logic [15:0] kd, input bit rdy);
        bit do_pop;
        bit do_push;
        bit room;
        int code;
        do_pop  = rdy && (m_q.size() > 0);
        room    = (m_q.size() < int'(DEPTH)) || do_pop;
        do_push = 1'b0;
        code    = 0;
        m_clear = 1'b0;
        case (m_state)
            M_IDLE: begin
                if (kd != 16'h0) begin
                    for (int i = 0; i < 16; i++)
                        if (kd[i]) m_pending.push_back(i);
                    m_clear = 1'b1;
                    m_state = M_DRAIN;
                end
            end
            M_DRAIN: begin
                if (m_pending.size() > 0 && room) begin
                    code    = m_pending.pop_front();
                    do_push = 1'b1;
                end
                if (m_pending.size() == 0) begin
                    m_state      = M_GUARD;
                    m_guard_left = int'(GUARD);
                end
            end
            M_GUARD: begin
                m_guard_left--;
                if (m_guard_left == 0) m_state = M_IDLE;
            end
            default: ;
        endcase
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(code);
    endtask

    // Called at posedge+1: apply ready, advance model and keypad over one edge,
    // then compare all outputs against the model.
    task automatic cycle(input bit rdy, input logic [15:0] press);
        logic [15:0] kd_next;
        evt_ready = rdy;
        if (evt_valid && rdy) popped.push_back(int'(evt_code));
        model_step(kd_cur, rdy);
        kd_next = (key_clear ? 16'h0 : kd_cur) | press;
        @(posedge clk);
        #1;
        kd_cur        = kd_next;
        key_data      = kd_cur;
        key_interrupt = (press != 16'h0);
        if (key_clear) clear_pulses++;
        check_outputs();
    endtask

    initial begin
        bit          r;
        int          rp;
        logic [15:0] p;

        rstn          = 1'b0;
        evt_ready     = 1'b0;
        key_data      = 16'h0;
        key_interrupt = 1'b0;
        kd_cur        = 16'h0;
        clear_pulses  = 0;
        model_reset();

        // Reset state
        #12;
        check_outputs();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // 1: single key
        clear_pulses = 0;
        popped.delete();
        cycle(1'b1, 16'h0020);
        cycle(1'b1, 16'h0);
        check_val("t1_clear_on", 32'(key_clear), 32'd1);
        cycle(1'b1, 16'h0);
        check_val("t1_clear_off", 32'(key_clear), 32'd0);
        check_val("t1_valid", 32'(evt_valid), 32'd1);
        check_val("t1_code", 32'(evt_code), 32'd5);
        cycle(1'b1, 16'h0);
        check_val("t1_level", 32'(evt_level), 32'd0);
        check_val("t1_busy", 32'(busy), 32'd0);
        repeat (3) cycle(1'b1, 16'h0);
        check_val("t1_clears", 32'(clear_pulses), 32'd1);
        check_pops("t1_pops", '{5});

        // 2: multi-key ordering under no-ready
        clear_pulses = 0;
        popped.delete();
        cycle(1'b0, 16'h8421);
        repeat (8) cycle(1'b0, 16'h0);
        check_val("t2_level", 32'(evt_level), 32'd4);
        check_val("t2_busy", 32'(busy), 32'd0);
        check_val("t2_clears", 32'(clear_pulses), 32'd1);
        repeat (6) cycle(1'b1, 16'h0);
        check_val("t2_level_end", 32'(evt_level), 32'd0);
        check_pops("t2_pops", '{0, 5, 10, 15});

        // 3 and 4: backpressure stall, then full with concurrent pop
        clear_pulses = 0;
        popped.delete();
        cycle(1'b0, 16'h003F);
        repeat (10) cycle(1'b0, 16'h0);
        check_val("t3_level_full", 32'(evt_level), 32'd4);
        check_val("t3_busy_stall", 32'(busy), 32'd1);
        cycle(1'b1, 16'h0);
        check_val("t4_level_hold", 32'(evt_level), 32'd4);
        check_val("t4_head", 32'(evt_code), 32'd1);
        repeat (12) cycle(1'b1, 16'h0);
        check_val("t3_level_end", 32'(evt_level), 32'd0);
        check_val("t3_busy_end", 32'(busy), 32'd0);
        check_val("t3_clears", 32'(clear_pulses), 32'd1);
        check_pops("t3_pops", '{0, 1, 2, 3, 4, 5});

        // 5: press arriving during drain is picked up after the guard
        clear_pulses = 0;
        popped.delete();
        cycle(1'b1, 16'h0003);
        cycle(1'b1, 16'h0);
        cycle(1'b1, 16'h0002);
        repeat (8) cycle(1'b1, 16'h0);
        check_val("t5_clears", 32'(clear_pulses), 32'd2);
        check_pops("t5_pops", '{0, 1, 1});

        // 6: asynchronous reset in the middle of a drain
        cycle(1'b0, 16'h0007);
        repeat (3) cycle(1'b0, 16'h0);
        check_val("t6_level_pre", 32'(evt_level), 32'd2);
        check_val("t6_busy_pre", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        kd_cur   = 16'h0;
        key_data = 16'h0;
        check_outputs();
        check_val("t6_level_rst", 32'(evt_level), 32'd0);
        #2;
        rstn = 1'b1;
        clear_pulses = 0;
        @(posedge clk);
        #1;
        check_outputs();
        repeat (3) cycle(1'b1, 16'h0);
        check_val("t6_no_clear", 32'(clear_pulses), 32'd0);

        // Randomized presses with varying consumer readiness
        for (int blk = 0; blk < 20; blk++) begin
            rp = int'($urandom_range(0, 4));
            for (int c = 0; c < 40; c++) begin
                r = (int'($urandom_range(0, 3)) < rp);
                case ($urandom_range(0, 7))
                    0:       p = 16'($urandom);
                    1:       p = 16'h1 << $urandom_range(0, 15);
                    default: p = 16'h0;
                endcase
                cycle(r, p);
            end
        end
        repeat (40) cycle(1'b1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
